// File: rtl/mul_div_unit.sv
// Integer multiply/divide unit for the M extension. It accepts one op at a time and returns the result tagged with the instruction id.
// Latency: MUL* completes after MUL_CYCLES enabled edges. DIV/REM by zero or signed overflow completes after 1 edge; other DIV/REM ops complete after XLEN+1 edges.
// Backpressure: unit_available is low while an op is in flight. rdy_in=0 freezes all state, and flush_pipline aborts the op in flight.
module mul_div_unit #(
    parameter int XLEN       = 32,
    parameter int ID_W       = 3,
    parameter int MUL_CYCLES = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            flush_pipline,
    input  logic            have_ins,
    input  logic [ID_W-1:0] ins_id,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [2:0]      funct3,
    output logic            unit_available,
    output logic            res_rdy,
    output logic [XLEN-1:0] res_val,
    output logic [ID_W-1:0] res_ins_id
);

    localparam int CNT_MAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic [ID_W-1:0] tag_q, tag_d;
    // opa: multiplicand, or dividend magnitude shifting into the quotient
    // opb: multiplier, or divisor magnitude
    logic [XLEN-1:0] opa_q, opa_d, opb_q, opb_d;
    // rem: partial remainder, or the precomputed result of a trivial divide
    logic [XLEN-1:0] rem_q, rem_d;
    logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic            fast_q, fast_d;
    logic            res_rdy_d;
    logic [XLEN-1:0] res_val_d;
    logic [ID_W-1:0] res_id_d;

    logic              signed_div, rs1_neg, rs2_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   rs1_mag, rs2_mag, fast_res;
    logic              mul_sa, mul_sb;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN-1:0]   mul_res, quo_fix, rem_fix, div_res;
    logic [XLEN:0]     rem_sh, diff;

    assign unit_available = (state_q == ST_IDLE);

    // Operand preparation at issue, multiplier datapath, and one restoring-division step
    always_comb begin
        signed_div = ~funct3[0];
        rs1_neg    = signed_div & rs1_val[XLEN-1];
        rs2_neg    = signed_div & rs2_val[XLEN-1];
        rs1_mag    = rs1_neg ? -rs1_val : rs1_val;
        rs2_mag    = rs2_neg ? -rs2_val : rs2_val;
        div_zero   = (rs2_val == '0);
        div_ovf    = signed_div && (rs1_val == MIN_NEG) && (rs2_val == '1);
        if (div_zero)
            fast_res = funct3[1] ? rs1_val : '1;
        else
            fast_res = funct3[1] ? '0 : rs1_val;

        mul_sa  = (f3_q == 3'b001) || (f3_q == 3'b010);
        mul_sb  = (f3_q == 3'b001);
        a_ext   = {{XLEN{mul_sa & opa_q[XLEN-1]}}, opa_q};
        b_ext   = {{XLEN{mul_sb & opb_q[XLEN-1]}}, opb_q};
        prod    = a_ext * b_ext;
        mul_res = (f3_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

        rem_sh  = {rem_q, opa_q[XLEN-1]};
        diff    = rem_sh - {1'b0, opb_q};
        quo_fix = neg_quo_q ? -opa_q : opa_q;
        rem_fix = neg_rem_q ? -rem_q : rem_q;
        div_res = f3_q[1] ? rem_fix : quo_fix;
    end

    // Next-state and output logic; flush takes priority over issue and completion
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        tag_d     = tag_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        fast_d    = fast_q;
        res_rdy_d = 1'b0;
        res_val_d = res_val;
        res_id_d  = res_ins_id;

        if (flush_pipline) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (have_ins) begin
                        f3_d  = funct3;
                        tag_d = ins_id;
                        if (!funct3[2]) begin
                            state_d = ST_MUL;
                            cnt_d   = CNT_W'(MUL_CYCLES - 1);
                            opa_d   = rs1_val;
                            opb_d   = rs2_val;
                            fast_d  = 1'b0;
                        end else if (div_zero || div_ovf) begin
                            // Trivial divides reuse the MUL wait state with a zero count
                            // so they finish on the next edge without entering DIV.
                            state_d = ST_MUL;
                            cnt_d   = '0;
                            rem_d   = fast_res;
                            fast_d  = 1'b1;
                        end else begin
                            state_d   = ST_DIV;
                            cnt_d     = CNT_W'(XLEN);
                            opa_d     = rs1_mag;
                            opb_d     = rs2_mag;
                            rem_d     = '0;
                            neg_quo_d = rs1_neg ^ rs2_neg;
                            neg_rem_d = rs1_neg;
                            fast_d    = 1'b0;
                        end
                    end
                end
                ST_MUL: begin
                    if (cnt_q == '0) begin
                        state_d   = ST_IDLE;
                        res_rdy_d = 1'b1;
                        res_val_d = fast_q ? rem_q : mul_res;
                        res_id_d  = tag_q;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (!diff[XLEN]) begin
                            rem_d = diff[XLEN-1:0];
                            opa_d = {opa_q[XLEN-2:0], 1'b1};
                        end else begin
                            rem_d = rem_sh[XLEN-1:0];
                            opa_d = {opa_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        state_d   = ST_IDLE;
                        res_rdy_d = 1'b1;
                        res_val_d = div_res;
                        res_id_d  = tag_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register: synchronous reset, frozen on edges where rdy_in is low
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            f3_q       <= '0;
            tag_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            rem_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            fast_q     <= 1'b0;
            res_rdy    <= 1'b0;
            res_val    <= '0;
            res_ins_id <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            f3_q       <= f3_d;
            tag_q      <= tag_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            rem_q      <= rem_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            fast_q     <= fast_d;
            res_rdy    <= res_rdy_d;
            res_val    <= res_val_d;
            res_ins_id <= res_id_d;
        end
    end

endmodule
